// File: rtl/vga_timing_gen_if.sv
// Video timing bundle between the timing generator and a pixel renderer.
//   en          : run enable, driven by the consumer (0 freezes timing)
//   pix_ce      : one-clk pulse per pixel period
//   hsync/vsync : sync outputs, polarity set by the generator
//   hCount/vCount : raw line/frame position
//   bright, x, y  : active-area flag and coordinates (x/y are 0 outside)
//   line_start/frame_start : one-clk strobes after the wrap to 0
interface vga_timing_gen_if #(
  parameter int unsigned CNT_W = 10
);
  logic             en;
  logic             pix_ce;
  logic             hsync;
  logic             vsync;
  logic [CNT_W-1:0] hCount;
  logic [CNT_W-1:0] vCount;
  logic             bright;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             line_start;
  logic             frame_start;

  modport master (
    input  en,
    output pix_ce, hsync, vsync, hCount, vCount, bright, x, y, line_start, frame_start
  );

  modport slave (
    output en,
    input  pix_ce, hsync, vsync, hCount, vCount, bright, x, y, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator running in the system clock domain.
// A clock-enable divider produces one pix_ce per CLK_DIV clocks; the h/v counters advance on
// pix_ce and every decoded output is registered from the next counter values, so all outputs
// describe the same position in the same cycle.
// Ports:
//   i_clk   : system clock
//   i_reset : asynchronous active-high reset
//   bus     : vga_timing_gen_if master (en in; sync, counters, active area, strobes out)
module vga_timing_gen #(
  parameter int unsigned CNT_W    = 10,
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  vga_timing_gen_if.master      bus
);

  localparam int unsigned HTotal    = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned VTotal    = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned HActStart = H_SYNC + H_BP;
  localparam int unsigned HActEnd   = H_SYNC + H_BP + H_ACTIVE;
  localparam int unsigned VActStart = V_SYNC + V_BP;
  localparam int unsigned VActEnd   = V_SYNC + V_BP + V_ACTIVE;
  localparam int unsigned DivW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CNT_W-1:0] HLast   = CNT_W'(HTotal - 1);
  localparam logic [CNT_W-1:0] VLast   = CNT_W'(VTotal - 1);
  localparam logic [CNT_W-1:0] HOffset = CNT_W'(HActStart);
  localparam logic [CNT_W-1:0] VOffset = CNT_W'(VActStart);
  localparam logic [DivW-1:0]  DivLast = DivW'(CLK_DIV - 1);

  // Elaboration-time sanity checks.
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end
  if (((HTotal - 1) >> CNT_W) != 0) begin : g_bad_htotal
    $error("vga_timing_gen: H_TOTAL does not fit in CNT_W bits");
  end
  if (((VTotal - 1) >> CNT_W) != 0) begin : g_bad_vtotal
    $error("vga_timing_gen: V_TOTAL does not fit in CNT_W bits");
  end

  logic [DivW-1:0]  r_div;
  logic [DivW-1:0]  w_div_next;
  logic             w_pix_ce;
  logic [CNT_W-1:0] r_hcount;
  logic [CNT_W-1:0] r_vcount;
  logic [CNT_W-1:0] w_h_next;
  logic [CNT_W-1:0] w_v_next;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic             w_hsync;
  logic             w_vsync;
  logic             w_bright;
  logic [CNT_W-1:0] w_x;
  logic [CNT_W-1:0] w_y;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_bright;
  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;
  logic             r_line_start;
  logic             r_frame_start;

  // pix_ce is combinational so that with CLK_DIV=1 it simply follows en; the reset term keeps it
  // low while reset is held.
  assign w_pix_ce = bus.en & ~i_reset & (r_div == DivLast);

  always_comb begin
    w_div_next = r_div;
    if (bus.en) begin
      w_div_next = (r_div == DivLast) ? '0 : r_div + DivW'(1);
    end
  end

  always_comb begin
    w_h_next = r_hcount;
    w_v_next = r_vcount;
    w_h_wrap = 1'b0;
    w_v_wrap = 1'b0;
    if (w_pix_ce) begin
      if (r_hcount < HLast) begin
        w_h_next = r_hcount + CNT_W'(1);
      end else begin
        w_h_next = '0;
        w_h_wrap = 1'b1;
        if (r_vcount == VLast) begin
          w_v_next = '0;
          w_v_wrap = 1'b1;
        end else begin
          w_v_next = r_vcount + CNT_W'(1);
        end
      end
    end
  end

  // Decode from the next counter values so the registered outputs line up with the counters.
  always_comb begin
    w_hsync  = (32'(w_h_next) < H_SYNC) ? HS_POL : ~HS_POL;
    w_vsync  = (32'(w_v_next) < V_SYNC) ? VS_POL : ~VS_POL;
    w_bright = (32'(w_h_next) >= HActStart) && (32'(w_h_next) < HActEnd) &&
               (32'(w_v_next) >= VActStart) && (32'(w_v_next) < VActEnd);
    w_x      = '0;
    w_y      = '0;
    if (w_bright) begin
      w_x = w_h_next - HOffset;
      w_y = w_v_next - VOffset;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_div         <= '0;
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_hsync       <= HS_POL;
      r_vsync       <= VS_POL;
      r_bright      <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_div         <= w_div_next;
      r_hcount      <= w_h_next;
      r_vcount      <= w_v_next;
      r_hsync       <= w_hsync;
      r_vsync       <= w_vsync;
      r_bright      <= w_bright;
      r_x           <= w_x;
      r_y           <= w_y;
      r_line_start  <= w_h_wrap;
      r_frame_start <= w_h_wrap & w_v_wrap;
    end
  end

  assign bus.pix_ce      = w_pix_ce;
  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.hCount      = r_hcount;
  assign bus.vCount      = r_vcount;
  assign bus.bright      = r_bright;
  assign bus.x           = r_x;
  assign bus.y           = r_y;
  // Strobes are suppressed while frozen.
  assign bus.line_start  = r_line_start & bus.en;
  assign bus.frame_start = r_frame_start & bus.en;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: three instances (default mode, small mode, default
// timing with inverted sync polarity and CLK_DIV=1). Stimulus pushes expected snapshots keyed
// by the clock count since reset release; per-instance monitors pop and compare on negedges.
module tb_vga_timing_gen;

  typedef struct {
    int          cyc;
    string       name;
    logic [9:0]  h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic        br;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        ce;
    logic        ls;
    logic        fs;
  } rec_t;

  logic clk;
  logic rst_a;
  logic rst_bc;
  int   cyc_a;
  int   cyc_bc;
  int   n_checks;
  int   n_fail;
  rec_t q_a[$];
  rec_t q_b[$];
  rec_t q_c[$];
  rec_t exp_a, act_a, exp_b, act_b, exp_c, act_c;

  vga_timing_gen_if #(.CNT_W(10)) bus_a ();
  vga_timing_gen_if #(.CNT_W(10)) bus_b ();
  vga_timing_gen_if #(.CNT_W(10)) bus_c ();

  vga_timing_gen u_dut_a (
    .i_clk   (clk),
    .i_reset (rst_a),
    .bus     (bus_a)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_SYNC(2), .H_BP(1), .H_ACTIVE(4), .H_FP(1),
    .V_SYNC(1), .V_BP(1), .V_ACTIVE(3), .V_FP(1)
  ) u_dut_b (
    .i_clk   (clk),
    .i_reset (rst_bc),
    .bus     (bus_b)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .HS_POL(1'b0), .VS_POL(1'b0)
  ) u_dut_c (
    .i_clk   (clk),
    .i_reset (rst_bc),
    .bus     (bus_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or posedge rst_a) begin
    if (rst_a) cyc_a <= 0;
    else       cyc_a <= cyc_a + 1;
  end

  always @(posedge clk or posedge rst_bc) begin
    if (rst_bc) cyc_bc <= 0;
    else        cyc_bc <= cyc_bc + 1;
  end

  function automatic rec_t mk(int cyc, string name, int h, int v, int hs, int vs, int br,
                              int x, int y, int ce, int ls, int fs);
    rec_t r;
    r.cyc  = cyc;
    r.name = name;
    r.h    = 10'(h);
    r.v    = 10'(v);
    r.hs   = (hs != 0);
    r.vs   = (vs != 0);
    r.br   = (br != 0);
    r.x    = 10'(x);
    r.y    = 10'(y);
    r.ce   = (ce != 0);
    r.ls   = (ls != 0);
    r.fs   = (fs != 0);
    return r;
  endfunction

  function automatic void cmp(rec_t e, rec_t a);
    n_checks++;
    if (a.h !== e.h || a.v !== e.v || a.hs !== e.hs || a.vs !== e.vs || a.br !== e.br ||
        a.x !== e.x || a.y !== e.y || a.ce !== e.ce || a.ls !== e.ls || a.fs !== e.fs) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got h=%0d v=%0d hs=%b vs=%b br=%b x=%0d y=%0d ce=%b ls=%b fs=%b",
               e.name, e.cyc, a.h, a.v, a.hs, a.vs, a.br, a.x, a.y, a.ce, a.ls, a.fs);
      $display("     %s expected h=%0d v=%0d hs=%b vs=%b br=%b x=%0d y=%0d ce=%b ls=%b fs=%b",
               e.name, e.h, e.v, e.hs, e.vs, e.br, e.x, e.y, e.ce, e.ls, e.fs);
    end
  endfunction

  function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst_a && q_a.size() != 0 && q_a[0].cyc == cyc_a) begin
      exp_a = q_a.pop_front();
      act_a = mk(cyc_a, exp_a.name, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      act_a.h  = bus_a.hCount;  act_a.v  = bus_a.vCount;
      act_a.hs = bus_a.hsync;   act_a.vs = bus_a.vsync;  act_a.br = bus_a.bright;
      act_a.x  = bus_a.x;       act_a.y  = bus_a.y;      act_a.ce = bus_a.pix_ce;
      act_a.ls = bus_a.line_start; act_a.fs = bus_a.frame_start;
      cmp(exp_a, act_a);
    end
  end

  always @(negedge clk) begin
    if (!rst_bc && q_b.size() != 0 && q_b[0].cyc == cyc_bc) begin
      exp_b = q_b.pop_front();
      act_b = mk(cyc_bc, exp_b.name, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      act_b.h  = bus_b.hCount;  act_b.v  = bus_b.vCount;
      act_b.hs = bus_b.hsync;   act_b.vs = bus_b.vsync;  act_b.br = bus_b.bright;
      act_b.x  = bus_b.x;       act_b.y  = bus_b.y;      act_b.ce = bus_b.pix_ce;
      act_b.ls = bus_b.line_start; act_b.fs = bus_b.frame_start;
      cmp(exp_b, act_b);
    end
  end

  always @(negedge clk) begin
    if (!rst_bc && q_c.size() != 0 && q_c[0].cyc == cyc_bc) begin
      exp_c = q_c.pop_front();
      act_c = mk(cyc_bc, exp_c.name, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      act_c.h  = bus_c.hCount;  act_c.v  = bus_c.vCount;
      act_c.hs = bus_c.hsync;   act_c.vs = bus_c.vsync;  act_c.br = bus_c.bright;
      act_c.x  = bus_c.x;       act_c.y  = bus_c.y;      act_c.ce = bus_c.pix_ce;
      act_c.ls = bus_c.line_start; act_c.fs = bus_c.frame_start;
      cmp(exp_c, act_c);
    end
  end

  // Waits (bounded) until cyc_a reaches target, leaving time at posedge+1.
  task automatic wait_cyc_a(input int target);
    int i;
    i = 0;
    while (cyc_a != target && i < 20000) begin
      @(posedge clk);
      #1;
      i++;
    end
    if (cyc_a != target) begin
      n_checks++;
      n_fail++;
      $display("FAIL a_wait_cyc got=%0d expected=%0d", cyc_a, target);
    end
  endtask

  task automatic drain_a();
    int i;
    i = 0;
    while (q_a.size() != 0 && i < 20000) begin
      @(posedge clk);
      i++;
    end
  endtask

  task automatic stim_a();
    rst_a     = 1'b1;
    bus_a.en  = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_a = 1'b0;
    //            cyc    name               h    v  hs vs br x  y  ce ls fs
    q_a.push_back(mk(0,     "a_reset",        0,   0, 1, 1, 0, 0, 0, 0, 0, 0));
    q_a.push_back(mk(3,     "a_first_ce",     0,   0, 1, 1, 0, 0, 0, 1, 0, 0));
    q_a.push_back(mk(4,     "a_first_step",   1,   0, 1, 1, 0, 0, 0, 0, 0, 0));
    q_a.push_back(mk(7,     "a_ce_period",    1,   0, 1, 1, 0, 0, 0, 1, 0, 0));
    q_a.push_back(mk(380,   "a_hs_last",      95,  0, 1, 1, 0, 0, 0, 0, 0, 0));
    q_a.push_back(mk(384,   "a_hs_off",       96,  0, 0, 1, 0, 0, 0, 0, 0, 0));
    q_a.push_back(mk(3196,  "a_line_end",     799, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    q_a.push_back(mk(3200,  "a_line_wrap",    0,   1, 1, 1, 0, 0, 0, 0, 1, 0));
    q_a.push_back(mk(3201,  "a_ls_single",    0,   1, 1, 1, 0, 0, 0, 0, 0, 0));
    q_a.push_back(mk(6400,  "a_vs_off",       0,   2, 1, 0, 0, 0, 0, 0, 1, 0));
    q_a.push_back(mk(8402,  "a_freeze_entry", 500, 2, 0, 0, 0, 0, 0, 0, 0, 0));
    q_a.push_back(mk(8404,  "a_frozen_1",     500, 2, 0, 0, 0, 0, 0, 0, 0, 0));
    q_a.push_back(mk(8411,  "a_frozen_2",     500, 2, 0, 0, 0, 0, 0, 0, 0, 0));
    q_a.push_back(mk(8413,  "a_resume_ce",    500, 2, 0, 0, 0, 0, 0, 1, 0, 0));
    q_a.push_back(mk(8414,  "a_resume_step",  501, 2, 0, 0, 0, 0, 0, 0, 0, 0));
    q_a.push_back(mk(10809, "a_no_skip_ce",   299, 3, 0, 0, 0, 0, 0, 1, 0, 0));
    q_a.push_back(mk(10810, "a_no_skip",      300, 3, 0, 0, 0, 0, 0, 0, 0, 0));

    // Freeze for 10 clocks at hCount=500 with the divider at 2.
    wait_cyc_a(8402);
    #1 bus_a.en = 1'b0;
    wait_cyc_a(8412);
    #1 bus_a.en = 1'b1;

    drain_a();
    // Mid-cycle asynchronous reset at hCount=300, vCount=3.
    @(posedge clk);
    #3 rst_a = 1'b1;
    #1;
    chk("a_async_h",  32'(bus_a.hCount), 0);
    chk("a_async_v",  32'(bus_a.vCount), 0);
    chk("a_async_hs", 32'(bus_a.hsync), 1);
    chk("a_async_vs", 32'(bus_a.vsync), 1);
    chk("a_async_ce", 32'(bus_a.pix_ce), 0);
    @(posedge clk);
    #2 rst_a = 1'b0;
    q_a.push_back(mk(0, "a_rel_reset", 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    q_a.push_back(mk(3, "a_rel_hold",  0, 0, 1, 1, 0, 0, 0, 1, 0, 0));
    q_a.push_back(mk(4, "a_rel_step",  1, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    drain_a();
  endtask

  task automatic stim_bc();
    int i;
    rst_bc   = 1'b1;
    bus_b.en = 1'b1;
    bus_c.en = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_bc = 1'b0;
    // Small mode: H_TOTAL=8, V_TOTAL=6, active h 3..6, v 2..4.
    q_b.push_back(mk(0,  "b_reset",        0, 0, 1, 1, 0, 0, 0, 1, 0, 0));
    q_b.push_back(mk(2,  "b_hs_off",       2, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    q_b.push_back(mk(8,  "b_line_wrap",    0, 1, 1, 0, 0, 0, 0, 1, 1, 0));
    q_b.push_back(mk(18, "b_before_act",   2, 2, 0, 0, 0, 0, 0, 1, 0, 0));
    q_b.push_back(mk(19, "b_first_bright", 3, 2, 0, 0, 1, 0, 0, 1, 0, 0));
    q_b.push_back(mk(38, "b_last_bright",  6, 4, 0, 0, 1, 3, 2, 1, 0, 0));
    q_b.push_back(mk(39, "b_fp_dark",      7, 4, 0, 0, 0, 0, 0, 1, 0, 0));
    q_b.push_back(mk(42, "b_vfp_dark",     2, 5, 0, 0, 0, 0, 0, 1, 0, 0));
    q_b.push_back(mk(47, "b_frame_end",    7, 5, 0, 0, 0, 0, 0, 1, 0, 0));
    q_b.push_back(mk(48, "b_frame_start",  0, 0, 1, 1, 0, 0, 0, 1, 1, 1));
    q_b.push_back(mk(49, "b_fs_single",    1, 0, 1, 1, 0, 0, 0, 1, 0, 0));
    q_b.push_back(mk(96, "b_frame_2",      0, 0, 1, 1, 0, 0, 0, 1, 1, 1));
    // Default timing, CLK_DIV=1, active-low syncs.
    q_c.push_back(mk(0,     "c_reset",        0,   0,  0, 0, 0, 0,   0, 1, 0, 0));
    q_c.push_back(mk(95,    "c_hs_last",      95,  0,  0, 0, 0, 0,   0, 1, 0, 0));
    q_c.push_back(mk(96,    "c_hs_off",       96,  0,  1, 0, 0, 0,   0, 1, 0, 0));
    q_c.push_back(mk(800,   "c_line_wrap",    0,   1,  0, 0, 0, 0,   0, 1, 1, 0));
    q_c.push_back(mk(1600,  "c_vs_off",       0,   2,  0, 1, 0, 0,   0, 1, 1, 0));
    q_c.push_back(mk(28143, "c_before_act",   143, 35, 1, 1, 0, 0,   0, 1, 0, 0));
    q_c.push_back(mk(28144, "c_first_bright", 144, 35, 1, 1, 1, 0,   0, 1, 0, 0));
    q_c.push_back(mk(28145, "c_x_step",       145, 35, 1, 1, 1, 1,   0, 1, 0, 0));
    q_c.push_back(mk(28783, "c_last_col",     783, 35, 1, 1, 1, 639, 0, 1, 0, 0));
    q_c.push_back(mk(28784, "c_fp_dark",      784, 35, 1, 1, 0, 0,   0, 1, 0, 0));
    i = 0;
    while ((q_b.size() != 0 || q_c.size() != 0) && i < 30000) begin
      @(posedge clk);
      i++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_a    = 1'b1;
    rst_bc   = 1'b1;
    fork
      stim_a();
      stim_bc();
    join
    repeat (2) @(posedge clk);
    while (q_a.size() != 0) begin
      exp_a = q_a.pop_front();
      n_checks++; n_fail++;
      $display("FAIL %s never reached got=unchecked expected=cyc %0d", exp_a.name, exp_a.cyc);
    end
    while (q_b.size() != 0) begin
      exp_b = q_b.pop_front();
      n_checks++; n_fail++;
      $display("FAIL %s never reached got=unchecked expected=cyc %0d", exp_b.name, exp_b.cyc);
    end
    while (q_c.size() != 0) begin
      exp_c = q_c.pop_front();
      n_checks++; n_fail++;
      $display("FAIL %s never reached got=unchecked expected=cyc %0d", exp_c.name, exp_c.cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
